// File: rtl/ibex_pkg.sv
// Shared fetch-path types and constants: widest supported fetch entry and halfword helpers.
package ibex_pkg;

  localparam int unsigned FETCH_BUS_W_MAX = 64;
  localparam int unsigned FETCH_HW_W      = 16;
  localparam int unsigned FETCH_HW_MAX    = FETCH_BUS_W_MAX / FETCH_HW_W;
  localparam int unsigned FETCH_HW_IDX_W  = $clog2(FETCH_HW_MAX);

  // Entries are always stored at the widest bus width; narrower buses zero-fill the top.
  typedef struct packed {
    logic [FETCH_BUS_W_MAX-1:0] data;
    logic                       err;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_IN,
    SRC_RD,
    SRC_NXT
  } fetch_src_e;

  function automatic logic [FETCH_HW_W-1:0] fetch_hw(fetch_entry_t e,
                                                     logic [FETCH_HW_IDX_W-1:0] idx);
    logic [FETCH_HW_MAX-1:0][FETCH_HW_W-1:0] hw;
    hw = e.data;
    return hw[idx];
  endfunction

  function automatic logic is_compressed(logic [FETCH_HW_W-1:0] hw);
    return hw[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/ibex_fetch_hw_select.sv
// Combinational halfword extractor: picks the low (L) and high (U) instruction halfwords,
// their error bits and availability from the head entry, the entry after it, or the bus input.
module ibex_fetch_hw_select
  import ibex_pkg::*;
#(
  parameter int unsigned BUS_W = 32
) (
  input  fetch_entry_t              i_rd_entry,
  input  fetch_entry_t              i_nxt_entry,
  input  fetch_entry_t              i_in_entry,
  input  logic                      i_in_valid,
  input  logic                      i_cnt_ge1,
  input  logic                      i_cnt_ge2,
  input  logic [FETCH_HW_IDX_W-1:0] i_h,
  output logic [FETCH_HW_W-1:0]     o_l,
  output logic [FETCH_HW_W-1:0]     o_u,
  output logic                      o_l_err,
  output logic                      o_u_err,
  output logic                      o_l_avail,
  output logic                      o_u_avail,
  output logic                      o_l_buf,
  output logic                      o_u_buf
);

  localparam logic [FETCH_HW_IDX_W-1:0] H_LAST = FETCH_HW_IDX_W'(BUS_W / FETCH_HW_W - 1);

  fetch_src_e                  w_l_src;
  fetch_src_e                  w_u_src;
  fetch_entry_t                w_l_entry;
  fetch_entry_t                w_u_entry;
  logic                        w_h_last;
  logic [FETCH_HW_IDX_W-1:0]   w_u_idx;

  assign w_h_last = (i_h == H_LAST);
  assign w_u_idx  = w_h_last ? '0 : i_h + FETCH_HW_IDX_W'(1);

  always_comb begin
    w_l_src = SRC_NONE;
    w_u_src = SRC_NONE;
    if (i_cnt_ge1) begin
      w_l_src = SRC_RD;
    end
`ifdef IBEX_FETCH_FIFO_BYPASS_EN
    else if (i_in_valid) begin
      w_l_src = SRC_IN;
    end
`endif
    // U lives in the same entry as L unless L is the last halfword of its entry.
    if (!w_h_last) begin
      w_u_src = w_l_src;
    end else if (i_cnt_ge2) begin
      w_u_src = SRC_NXT;
    end
`ifdef IBEX_FETCH_FIFO_BYPASS_EN
    else if (i_cnt_ge1 && i_in_valid) begin
      w_u_src = SRC_IN;
    end
`endif
  end

`ifndef IBEX_FETCH_FIFO_BYPASS_EN
  logic w_unused_in_valid;
  assign w_unused_in_valid = i_in_valid;
`endif

  always_comb begin
    w_l_entry = i_rd_entry;
    case (w_l_src)
      SRC_IN:  w_l_entry = i_in_entry;
      SRC_NXT: w_l_entry = i_nxt_entry;
      default: w_l_entry = i_rd_entry;
    endcase
  end

  always_comb begin
    w_u_entry = i_rd_entry;
    case (w_u_src)
      SRC_IN:  w_u_entry = i_in_entry;
      SRC_NXT: w_u_entry = i_nxt_entry;
      default: w_u_entry = i_rd_entry;
    endcase
  end

  assign o_l       = fetch_hw(w_l_entry, i_h);
  assign o_u       = fetch_hw(w_u_entry, w_u_idx);
  assign o_l_err   = w_l_entry.err;
  assign o_u_err   = w_u_entry.err;
  assign o_l_avail = (w_l_src != SRC_NONE);
  assign o_u_avail = (w_u_src != SRC_NONE);
  assign o_l_buf   = (w_l_src == SRC_RD) || (w_l_src == SRC_NXT);
  assign o_u_buf   = (w_u_src == SRC_RD) || (w_u_src == SRC_NXT);

endmodule

// File: rtl/ibex_fetch_fifo_wide.sv
// Wide instruction fetch FIFO: circular buffer of BUS_W-bit fetch responses, one 32-bit
// instruction out per handshake at any halfword address. Define IBEX_FETCH_FIFO_BYPASS_EN to
// let the bus response feed the output combinationally when the buffer lacks the data.
module ibex_fetch_fifo_wide
  import ibex_pkg::*;
#(
  parameter int unsigned NUM_REQS = 2,
  parameter int unsigned BUS_W    = 32,
  parameter int unsigned DEPTH    = NUM_REQS + 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clear_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [31:0]                in_addr_i,
  input  logic [BUS_W-1:0]           in_rdata_i,
  input  logic                       in_err_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [31:0]                out_addr_o,
  output logic [31:0]                out_rdata_o,
  output logic                       out_err_o,
  output logic                       out_buf_ins_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned H      = BUS_W / FETCH_HW_W;
  localparam int unsigned HIDX_W = $clog2(H);
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

  localparam logic [HIDX_W-1:0] H_LAST     = HIDX_W'(H - 1);
  localparam logic [HIDX_W-1:0] H_PENULT   = HIDX_W'(H - 2);
  localparam logic [PTR_W-1:0]  PTR_MAX    = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL   = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_RDYMAX = CNT_W'(DEPTH - NUM_REQS);

  fetch_entry_t r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd;
  logic [PTR_W-1:0] r_wr;
  logic [CNT_W-1:0] r_count;
  logic [31:1]      r_addr;

  fetch_entry_t          w_in_entry;
  logic [PTR_W-1:0]      w_rd_nxt;
  logic [PTR_W-1:0]      w_wr_nxt;
  logic [HIDX_W-1:0]     w_h;
  logic [FETCH_HW_W-1:0] w_l;
  logic [FETCH_HW_W-1:0] w_u;
  logic                  w_l_err;
  logic                  w_u_err;
  logic                  w_l_avail;
  logic                  w_u_avail;
  logic                  w_l_buf;
  logic                  w_u_buf;
  logic                  w_comp;
  logic                  w_valid;
  logic                  w_hs;
  logic                  w_last;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_unused_addr0;

  assign w_in_entry.data = FETCH_BUS_W_MAX'(in_rdata_i);
  assign w_in_entry.err  = in_err_i;
  assign w_unused_addr0  = in_addr_i[0];

  assign w_rd_nxt = (r_rd == PTR_MAX) ? '0 : r_rd + PTR_W'(1);
  assign w_wr_nxt = (r_wr == PTR_MAX) ? '0 : r_wr + PTR_W'(1);
  assign w_h      = r_addr[HIDX_W:1];

  ibex_fetch_hw_select #(
    .BUS_W(BUS_W)
  ) u_hw_select (
    .i_rd_entry (r_mem[r_rd]),
    .i_nxt_entry(r_mem[w_rd_nxt]),
    .i_in_entry (w_in_entry),
    .i_in_valid (in_valid_i),
    .i_cnt_ge1  (r_count != '0),
    .i_cnt_ge2  (r_count > CNT_W'(1)),
    .i_h        (FETCH_HW_IDX_W'(w_h)),
    .o_l        (w_l),
    .o_u        (w_u),
    .o_l_err    (w_l_err),
    .o_u_err    (w_u_err),
    .o_l_avail  (w_l_avail),
    .o_u_avail  (w_u_avail),
    .o_l_buf    (w_l_buf),
    .o_u_buf    (w_u_buf)
  );

  assign w_comp  = is_compressed(w_l);
  assign w_valid = w_l_avail & (w_comp | w_u_avail);
  assign w_hs    = w_valid & out_ready_i & ~clear_i;
  // An uncompressed instruction starting in the last halfword only borrows hw0 of the
  // following entry, so the head entry retires while the next one stays resident.
  assign w_last  = w_comp ? (w_h == H_LAST) : ((w_h == H_LAST) || (w_h == H_PENULT));
  assign w_push  = in_valid_i & ~clear_i;
  assign w_pop   = w_hs & w_last;

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr] <= w_in_entry;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
      r_addr  <= '0;
    end else if (clear_i) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
      r_addr  <= in_addr_i[31:1];
    end else begin
      if (w_push) begin
        r_wr <= w_wr_nxt;
      end
      if (w_pop) begin
        r_rd <= w_rd_nxt;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CNT_W'(1);
      end
      if (w_hs) begin
        r_addr <= r_addr + (w_comp ? 31'd1 : 31'd2);
      end
    end
  end

  assign in_ready_o  = (r_count <= CNT_RDYMAX);
  assign out_valid_o = w_valid;
  assign out_addr_o  = {r_addr, 1'b0};
  assign out_rdata_o = {w_u, w_l};
  assign out_err_o   = w_l_err | (~w_comp & w_u_err);
  assign count_o     = r_count;

`ifdef IBEX_FETCH_FIFO_BYPASS_EN
  assign out_buf_ins_o = w_valid & w_l_buf & (w_comp | w_u_buf);
`else
  logic w_unused_buf;
  assign w_unused_buf  = w_l_buf ^ w_u_buf;
  assign out_buf_ins_o = w_valid;
`endif

  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(w_push && !w_pop && (r_count == CNT_FULL)));

endmodule

// File: tb/tb_ibex_fetch_fifo_wide.sv
// Scoreboard bench for ibex_fetch_fifo_wide: one 32-bit and one 64-bit instance.
module tb_ibex_fetch_fifo_wide;

`ifdef IBEX_FETCH_FIFO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;
  logic rst_ni;

  logic        a_clear, a_in_valid, a_in_ready, a_in_err, a_out_valid, a_out_ready;
  logic        a_out_err, a_buf;
  logic [31:0] a_in_addr, a_in_rdata, a_out_addr, a_out_rdata;
  logic [2:0]  a_count;

  logic        b_clear, b_in_valid, b_in_ready, b_in_err, b_out_valid, b_out_ready;
  logic        b_out_err, b_buf;
  logic [31:0] b_in_addr, b_out_addr, b_out_rdata;
  logic [63:0] b_in_rdata;
  logic [2:0]  b_count;

  ibex_fetch_fifo_wide #(.NUM_REQS(2), .BUS_W(32), .DEPTH(6)) u_a (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(a_clear), .in_valid_i(a_in_valid),
    .in_ready_o(a_in_ready), .in_addr_i(a_in_addr), .in_rdata_i(a_in_rdata),
    .in_err_i(a_in_err), .out_valid_o(a_out_valid), .out_ready_i(a_out_ready),
    .out_addr_o(a_out_addr), .out_rdata_o(a_out_rdata), .out_err_o(a_out_err),
    .out_buf_ins_o(a_buf), .count_o(a_count)
  );

  ibex_fetch_fifo_wide #(.NUM_REQS(2), .BUS_W(64)) u_b (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(b_clear), .in_valid_i(b_in_valid),
    .in_ready_o(b_in_ready), .in_addr_i(b_in_addr), .in_rdata_i(b_in_rdata),
    .in_err_i(b_in_err), .out_valid_o(b_out_valid), .out_ready_i(b_out_ready),
    .out_addr_o(b_out_addr), .out_rdata_o(b_out_rdata), .out_err_o(b_out_err),
    .out_buf_ins_o(b_buf), .count_o(b_count)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] rdata;
    logic        err;
    logic        buf_ins;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input exp_t e, input logic [31:0] addr,
                         input logic [31:0] rdata, input logic err, input logic bi);
    logic [31:0] mask;
    mask = (e.rdata[1:0] != 2'b11) ? 32'h0000_ffff : 32'hffff_ffff;
    check({tag, "_addr"}, addr, e.addr);
    check({tag, "_rdata"}, rdata & mask, e.rdata & mask);
    check({tag, "_err"}, {31'd0, err}, {31'd0, e.err});
    check({tag, "_buf_ins"}, {31'd0, bi}, {31'd0, e.buf_ins});
  endtask

  always @(negedge clk_i) begin
    if (rst_ni && a_out_valid && a_out_ready && !a_clear) begin
      if (qa.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL a_unexpected: got instr at %h expected none", a_out_addr);
      end else begin
        exp_t e;
        e = qa.pop_front();
        chk_out("a", e, a_out_addr, a_out_rdata, a_out_err, a_buf);
      end
    end
  end

  always @(negedge clk_i) begin
    if (rst_ni && b_out_valid && b_out_ready && !b_clear) begin
      if (qb.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL b_unexpected: got instr at %h expected none", b_out_addr);
      end else begin
        exp_t e;
        e = qb.pop_front();
        chk_out("b", e, b_out_addr, b_out_rdata, b_out_err, b_buf);
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic exp_a(input logic [31:0] addr, input logic [31:0] rdata, input logic err,
                       input logic bi);
    exp_t e;
    e.addr = addr; e.rdata = rdata; e.err = err; e.buf_ins = bi;
    qa.push_back(e);
  endtask

  task automatic exp_b(input logic [31:0] addr, input logic [31:0] rdata, input logic err);
    exp_t e;
    e.addr = addr; e.rdata = rdata; e.err = err; e.buf_ins = 1'b1;
    qb.push_back(e);
  endtask

  task automatic a_push(input logic [31:0] d, input logic e);
    a_in_valid = 1'b1; a_in_rdata = d; a_in_err = e;
    tick();
    a_in_valid = 1'b0; a_in_err = 1'b0;
  endtask

  task automatic b_push(input logic [63:0] d, input logic e);
    b_in_valid = 1'b1; b_in_rdata = d; b_in_err = e;
    tick();
    b_in_valid = 1'b0; b_in_err = 1'b0;
  endtask

  task automatic a_clear_to(input logic [31:0] addr);
    a_clear = 1'b1; a_in_addr = addr;
    tick();
    a_clear = 1'b0;
  endtask

  task automatic b_clear_to(input logic [31:0] addr);
    b_clear = 1'b1; b_in_addr = addr;
    tick();
    b_clear = 1'b0;
  endtask

  task automatic drain_a(input string name);
    a_out_ready = 1'b1;
    for (int i = 0; i < 40 && qa.size() != 0; i++) tick();
    check({name, "_pending"}, qa.size(), 0);
    a_out_ready = 1'b0;
  endtask

  task automatic drain_b(input string name);
    b_out_ready = 1'b1;
    for (int i = 0; i < 40 && qb.size() != 0; i++) tick();
    check({name, "_pending"}, qb.size(), 0);
    b_out_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    rst_ni = 1'b0;
    a_clear = 0; a_in_valid = 0; a_in_err = 0; a_out_ready = 0; a_in_addr = 0; a_in_rdata = 0;
    b_clear = 0; b_in_valid = 0; b_in_err = 0; b_out_ready = 0; b_in_addr = 0; b_in_rdata = 0;
    repeat (3) tick();
    check("reset_a_count", a_count, 0);
    check("reset_a_in_ready", a_in_ready, 1);
    check("reset_a_out_valid", a_out_valid, 0);
    rst_ni = 1'b1;
    tick();
    check("reset_a_addr", a_out_addr, 0);
    check("reset_b_count", b_count, 0);
    check("reset_b_in_ready", b_in_ready, 1);

    // Single uncompressed response into an empty buffer
    a_clear_to(32'h100);
    check("clr_a_addr", a_out_addr, 32'h100);
    check("clr_a_count", a_count, 0);
    exp_a(32'h100, 32'h0000_0013, 1'b0, !BYP);
    a_out_ready = 1'b1;
    a_in_valid = 1'b1; a_in_rdata = 32'h0000_0013;
    @(negedge clk_i);
    check("lat_a_valid", a_out_valid, BYP);
    tick();
    a_in_valid = 1'b0;
    drain_a("lat");
    check("lat_a_addr", a_out_addr, 32'h104);
    check("lat_a_count", a_count, 0);

    // Compressed then straddling instruction, error only on second entry
    a_clear_to(32'h0);
    exp_a(32'h0, 32'h0000_4501, 1'b0, 1'b1);
    exp_a(32'h2, 32'h0000_0513, 1'b1, 1'b1);
    exp_a(32'h6, 32'h0000_0000, 1'b1, 1'b1);
    a_push(32'h0513_4501, 1'b0);
    a_push(32'h0000_0000, 1'b1);
    check("strad_a_count", a_count, 2);
    drain_a("strad");
    check("strad_a_count_end", a_count, 0);
    check("strad_a_addr", a_out_addr, 32'h8);

    // Occupancy and in_ready threshold
    a_clear_to(32'h200);
    for (int k = 0; k < 5; k++) begin
      logic [31:0] d;
      d = 32'h0000_0013 | (32'(k) << 20);
      exp_a(32'h200 + 32'(4 * k), d, 1'b0, 1'b1);
      a_push(d, 1'b0);
      check("occ_a_in_ready", a_in_ready, (k < 4) ? 32'd1 : 32'd0);
    end
    check("occ_a_count", a_count, 5);
    a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;
    check("occ_a_count_pop", a_count, 4);
    check("occ_a_in_ready_pop", a_in_ready, 1);
    drain_a("occ");
    check("occ_a_count_end", a_count, 0);

    // Clear while a response arrives
    a_clear_to(32'h300);
    a_push(32'h1111_1113, 1'b0);
    a_push(32'h2222_2223, 1'b0);
    a_push(32'h3333_3333, 1'b0);
    check("flush_a_count_pre", a_count, 3);
    a_clear = 1'b1; a_in_addr = 32'h400; a_in_valid = 1'b1; a_in_rdata = 32'hDEAD_BEEF;
    tick();
    a_clear = 1'b0; a_in_valid = 1'b0;
    check("flush_a_count", a_count, 0);
    check("flush_a_addr", a_out_addr, 32'h400);
    check("flush_a_valid", a_out_valid, 0);
    exp_a(32'h400, 32'h00A0_0093, 1'b0, 1'b1);
    a_push(32'h00A0_0093, 1'b0);
    check("flush_a_count_push", a_count, 1);
    drain_a("flush");
    check("flush_a_count_end", a_count, 0);

    // 64-bit bus: three instructions from one entry
    b_clear_to(32'h0);
    exp_b(32'h0, 32'h0000_0513, 1'b0);
    exp_b(32'h4, 32'h0000_4501, 1'b0);
    exp_b(32'h6, 32'h0000_0001, 1'b0);
    b_push(64'h0001_4501_0000_0513, 1'b0);
    check("w64_b_count", b_count, 1);
    drain_b("w64");
    check("w64_b_count_end", b_count, 0);
    check("w64_b_addr", b_out_addr, 32'h8);

    // 64-bit bus: masked error on last-halfword compressed, straddle across entries
    exp_b(32'h08, 32'h0000_4501, 1'b0);
    exp_b(32'h0a, 32'h0000_4501, 1'b0);
    exp_b(32'h0c, 32'h0000_4501, 1'b0);
    exp_b(32'h0e, 32'h0000_0001, 1'b0);
    exp_b(32'h10, 32'h0000_0001, 1'b1);
    exp_b(32'h12, 32'h0000_0000, 1'b1);
    exp_b(32'h14, 32'h0000_0000, 1'b1);
    exp_b(32'h16, 32'h0001_0513, 1'b1);
    exp_b(32'h1a, 32'h0000_0000, 1'b0);
    exp_b(32'h1c, 32'h0000_0000, 1'b0);
    exp_b(32'h1e, 32'h0000_0000, 1'b0);
    b_push(64'h0001_4501_4501_4501, 1'b0);
    b_push(64'h0513_0000_0000_0001, 1'b1);
    b_push(64'h0000_0000_0000_0001, 1'b0);
    check("seq_b_count", b_count, 3);
    check("seq_b_in_ready", b_in_ready, 1);
    drain_b("seq");
    check("seq_b_count_end", b_count, 0);
    check("seq_b_addr", b_out_addr, 32'h20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
